// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared types and defaults for the instruction fetch queue
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int DEPTH_DEFAULT = 4;

  // addi x0, x0, 0
  localparam logic [XLEN_DEFAULT-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : DEPTH-entry synchronous FIFO of fetch_entry_t with flush
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t       mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               full;
  logic               push_ok;
  logic               pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits so they wrap modulo DEPTH for free.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_queue.sv
// ============================================================================
// instr_fetch_queue : credit-based fetch issue with a decode-side queue.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when empty.
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int XLEN  = XLEN_DEFAULT   // must match the fetch_entry_t field width
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [XLEN-1:0] PC,
  output logic            EN,
  input  logic            FLUSH,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic [XLEN-1:0] IMEM_RDATA,
  output logic [XLEN-1:0] INSTR,
  output logic [XLEN-1:0] INSTR_PC,
  output logic            VALID,
  input  logic            READY
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            inflight;
  logic [XLEN-1:0] tag;
  logic [CW-1:0]   occupancy;
  logic [CW:0]     credit_used;
  logic            issue;
  logic            response;
  logic            bypass;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  fetch_entry_t    head;
  fetch_entry_t    resp_entry;
  logic [XLEN-1:0] hold_instr;
  logic [XLEN-1:0] hold_pc;

  // Credit counts both stored entries and the read still on its way back.
  assign credit_used = {1'b0, occupancy} + {{CW{1'b0}}, inflight};
  assign issue       = !RESET && !FLUSH && (credit_used < (CW+1)'(DEPTH));

  assign IMEM_REQ  = issue;
  assign IMEM_ADDR = PC;
  assign EN        = (issue || FLUSH) && !RESET;

  assign response   = inflight && !FLUSH;
  assign resp_entry = '{pc: tag, instr: IMEM_RDATA};

`ifdef FETCH_BYPASS_EN
  assign bypass = response && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed response that decode takes this cycle never enters the queue.
  assign push = response && !(bypass && READY);
  assign pop  = READY && !FLUSH;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      inflight <= 1'b0;
      tag      <= '0;
    end else begin
      inflight <= issue;
      if (issue) tag <= PC;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (push),
    .push_data (resp_entry),
    .pop       (pop),
    .flush     (FLUSH),
    .head      (head),
    .count     (occupancy),
    .empty     (fifo_empty)
  );

  always_comb begin
    VALID    = 1'b0;
    INSTR    = hold_instr;
    INSTR_PC = hold_pc;
    if (!fifo_empty) begin
      VALID    = !FLUSH;
      INSTR    = head.instr;
      INSTR_PC = head.pc;
    end else if (bypass) begin
      VALID    = 1'b1;
      INSTR    = IMEM_RDATA;
      INSTR_PC = tag;
    end
  end

  // Keeps the last presented instruction visible while the queue is empty.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hold_instr <= '0;
      hold_pc    <= '0;
    end else begin
      hold_instr <= INSTR;
      hold_pc    <= INSTR_PC;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: vector table, corner sequences,
// and a randomized run against a queue-based reference model.
`default_nettype none

module tb_instr_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK, RESET, EN, FLUSH, IMEM_REQ, VALID, READY;
  logic [31:0] PC, IMEM_ADDR, IMEM_RDATA, INSTR, INSTR_PC;

  instr_fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .EN(EN), .FLUSH(FLUSH),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDATA(IMEM_RDATA),
    .INSTR(INSTR), .INSTR_PC(INSTR_PC), .VALID(VALID), .READY(READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: the PC register, the memory, and the decode queue.
  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];
  bit          inflight_m;
  logic [31:0] tag_m, pc_m, resp_addr;
  bit          resp_pend;

  // Values observed during the most recent step, for hand-written checks.
  logic        obs_en, obs_req, obs_valid;
  logic [31:0] obs_addr, obs_ipc, obs_instr;

  typedef struct {
    bit          ready;
    bit          exp_en;
    bit          exp_valid;
    logic [31:0] exp_ipc;
  } vec_t;
  vec_t tbl[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q_pc.delete();
    q_ins.delete();
    inflight_m = 1'b0;
    tag_m      = '0;
    pc_m       = '0;
    resp_addr  = '0;
    resp_pend  = 1'b0;
  endtask

  task automatic do_reset();
    FLUSH = 1'b0;
    READY = 1'b0;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("reset_en",       {31'b0, EN},       32'd0);
    chk("reset_req",      {31'b0, IMEM_REQ}, 32'd0);
    chk("reset_valid",    {31'b0, VALID},    32'd0);
    chk("reset_instr",    INSTR,             32'd0);
    chk("reset_instr_pc", INSTR_PC,          32'd0);
    model_clear();
    RESET = 1'b0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input bit rdy, input bit fl, input logic [31:0] tgt);
    bit          e_issue, e_byp, e_valid;
    logic [31:0] e_pc, e_ins;
    int          occ;
    READY      = rdy;
    FLUSH      = fl;
    PC         = pc_m;
    IMEM_RDATA = resp_pend ? (32'h1000 + resp_addr) : $urandom;
    #1;
    occ     = q_pc.size();
    e_issue = !fl && (occ + int'(inflight_m) < DEPTH);
    e_byp   = BYP && (occ == 0) && inflight_m && !fl;
    e_valid = !fl && (occ > 0 || e_byp);
    if (occ > 0) begin
      e_pc  = q_pc[0];
      e_ins = q_ins[0];
    end else begin
      e_pc  = tag_m;
      e_ins = IMEM_RDATA;
    end
    obs_en = EN; obs_req = IMEM_REQ; obs_valid = VALID;
    obs_addr = IMEM_ADDR; obs_ipc = INSTR_PC; obs_instr = INSTR;
    chk("en",       {31'b0, EN},       {31'b0, e_issue || fl});
    chk("imem_req", {31'b0, IMEM_REQ}, {31'b0, e_issue});
    chk("valid",    {31'b0, VALID},    {31'b0, e_valid});
    if (e_issue) chk("imem_addr", IMEM_ADDR, pc_m);
    if (e_valid) begin
      chk("instr_pc", INSTR_PC, e_pc);
      chk("instr",    INSTR,    e_ins);
    end
    if (fl) begin
      q_pc.delete();
      q_ins.delete();
    end else begin
      if (e_valid && rdy && !e_byp) begin
        void'(q_pc.pop_front());
        void'(q_ins.pop_front());
      end
      if (inflight_m && !(e_byp && rdy)) begin
        q_pc.push_back(tag_m);
        q_ins.push_back(IMEM_RDATA);
      end
    end
    resp_pend  = e_issue;
    resp_addr  = pc_m;
    inflight_m = e_issue;
    if (e_issue) tag_m = pc_m;
    if (fl)           pc_m = tgt;
    else if (e_issue) pc_m = pc_m + 32'd4;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b0; READY = 1'b0; FLUSH = 1'b0; PC = '0; IMEM_RDATA = '0;
    model_clear();

    // Fill with READY low, then drain and run at one per cycle with occupancy 2.
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, BYP,  32'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 32'h4};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'h8};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 32'hC};
    for (int n = 11; n < 23; n++) tbl[n] = '{1'b1, 1'b1, 1'b1, 32'(4 * (n - 7))};

    #1;
    do_reset();
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].ready, 1'b0, 32'h0);
      chk($sformatf("tbl%0d_en", i),    {31'b0, obs_en},    {31'b0, tbl[i].exp_en});
      chk($sformatf("tbl%0d_valid", i), {31'b0, obs_valid}, {31'b0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_ipc", i),   obs_ipc,   tbl[i].exp_ipc);
        chk($sformatf("tbl%0d_instr", i), obs_instr, 32'h1000 + tbl[i].exp_ipc);
      end
    end

    // Redirect with three entries queued and one read in flight.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h200);
    chk("flush_valid", {31'b0, obs_valid}, 32'd0);
    chk("flush_en",    {31'b0, obs_en},    32'd1);
    chk("flush_req",   {31'b0, obs_req},   32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("target_req",  {31'b0, obs_req},   32'd1);
    chk("target_addr", obs_addr,           32'h200);
    step(1'b1, 1'b0, 32'h0);
`ifdef FETCH_BYPASS_EN
    chk("target_byp_valid", {31'b0, obs_valid}, 32'd1);
    chk("target_byp_ipc",   obs_ipc,            32'h200);
    step(1'b1, 1'b0, 32'h0);
    chk("target_next_ipc",  obs_ipc,            32'h204);
`else
    chk("target_t2_valid", {31'b0, obs_valid}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("target_valid", {31'b0, obs_valid}, 32'd1);
    chk("target_ipc",   obs_ipc,            32'h200);
    chk("target_instr", obs_instr,          32'h1200);
`endif

`ifdef FETCH_BYPASS_EN
    // Empty queue with READY high: response goes straight to decode.
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("byp_valid", {31'b0, obs_valid}, 32'd1);
    chk("byp_instr", obs_instr,          32'h1000);
    step(1'b1, 1'b0, 32'h0);
    chk("byp_next_ipc", obs_ipc, 32'h4);
`endif

    // Randomized traffic with stalls and redirects.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bit rdy, fl;
      rdy = (i % 300 < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 24) == 0);
      step(rdy, fl, $urandom & 32'hFFFF_FFFC);
    end

    // Asynchronous reset mid-stream, even with FLUSH high.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
    FLUSH = 1'b1;
    RESET = 1'b1;
    #1;
    chk("async_rst_en",    {31'b0, EN},       32'd0);
    chk("async_rst_req",   {31'b0, IMEM_REQ}, 32'd0);
    chk("async_rst_valid", {31'b0, VALID},    32'd0);
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    chk("restart_req",  {31'b0, obs_req}, 32'd1);
    chk("restart_addr", obs_addr,         32'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
